handshake_fifo: RTL and testbench
=================================

// Module: handshake_fifo
// PURPOSE
//  Responder/forwarder end of the valid/ready handshake driven by the handshake_if bench.
//  Accepts words on the input side (i_value/i_valid, answered by o_ready).
//  Buffers them in a DEPTH-entry FIFO.
//  Presents them in order on the output side (o_value/o_valid, taken by i_ready).
//  Standard DUT behind handshake_if; also the elastic stage between producer/consumer blocks.
// PARAMETERS
//  VALUE_BITS  8   width of each transferred word
//  DEPTH       4   buffer entries; power of 2, >= 2
// PORTS
//  clock    input   1                     single clock, all logic on posedge
//  reset_n  input   1                     synchronous reset, active low
//  i_value  input   VALUE_BITS            upstream data
//  i_valid  input   1                     upstream data valid
//  o_ready  output  1                     block can accept i_value this cycle
//  o_value  output  VALUE_BITS            head-of-FIFO data
//  o_valid  output  1                     o_value valid
//  i_ready  input   1                     downstream accepts o_value this cycle
//  level    output  $clog2(DEPTH+1)       current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset: sampled at posedge while reset_n=0.
//    o_ready=0, o_valid=0, o_value='0, level=0; pointers cleared; stored contents discarded.
//  - First posedge with reset_n=1 sets o_ready=1.
//  - Push: occurs at the posedge where i_valid && o_ready are both 1.
//    i_value written at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
//  - Pop: occurs at the posedge where o_valid && i_ready are both 1.
//    rd_ptr advances with wrap; the next entry, if any, appears on o_value the same edge.
//  - i_valid and i_ready are ignored when the partner signal is 0.
//    No transfer happens on those edges.
//  - All outputs are registered.
//    No combinational path from any input to any output.
//  - o_ready is next-state !full.
//    o_valid is next-state (level != 0).
//    o_value is the next-state head entry, or '0 when empty.
//  - Latency: a word pushed into an empty FIFO at edge k gives o_valid=1 with that word after edge k.
//    It can be popped at edge k+1.
//  - Throughput: one push and one pop per cycle, sustained.
//  - level arithmetic: next = level + push - pop, evaluated at each posedge.
//    Push and pop on the same edge leave level unchanged; both pointers advance.
//  - Full (level==DEPTH): o_ready=0, so no push occurs.
//    Pop at full gives o_ready=1 after that edge; same-edge i_valid is not accepted.
//  - Push at level DEPTH-1 without pop gives o_ready=0 after that edge.
//  - Empty (level==0): o_valid=0, so no pop occurs. i_ready is irrelevant.
//  - Holding: while o_valid=1 && i_ready=0, o_value and o_valid stay stable.
//  - Wrap-around: ordering is preserved across pointer wrap for any interleaving.
//  - Reset mid-operation: reset_n=0 at any edge overrides push and pop.
//    Outputs take reset values after that edge; buffered data is lost.
//  - No overflow or underflow state exists. Violations are impossible by construction.
//    Assertions check level <= DEPTH and o_valid == (level != 0).
// TESTING  (VALUE_BITS=8, DEPTH=4 unless stated)
//  1 Reset: hold reset_n=0 for 3 cycles with i_valid=1, i_ready=1.
//    -> o_ready=0, o_valid=0, o_value=0, level=0.
//    -> One cycle after release, o_ready=1.
//  2 Single transfer: push 8'hA5 with i_ready=1.
//    -> o_valid=1, o_value=A5 one cycle later.
//    -> Popped on the next edge; then o_valid=0, level=0.
//  3 Fill/drain: i_ready=0, push 11,22,33,44 back-to-back.
//    -> level=4 and o_ready=0 after the 4th push.
//    -> A held 55 is not accepted.
//    -> Raise i_ready: outputs 11,22,33,44 on consecutive cycles, then 55 after it is accepted.
//  4 Simultaneous: at level=2, push and pop on the same edge for 6 cycles.
//    -> level stays 2, pointers wrap, output order matches input order.
//  5 Mid-operation reset: at level=3, pulse reset_n=0 for one cycle.
//    -> level=0, o_valid=0.
//    -> Subsequent push 8'h7E emerges first; no stale data.
//  6 Random: handshake_if with MAX_DELAY=10 drives 1000 random words on both sides.
//    -> Scoreboard shows all 1000 in order, none lost or duplicated, level <= 4 throughout.

Source files
------------

// File: rtl/handshake_fifo.sv
// Valid/ready elastic buffer: DEPTH-entry FIFO between an upstream producer and a
// downstream consumer, with every output driven straight from a flop.
module handshake_fifo #(
    parameter int VALUE_BITS = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [VALUE_BITS-1:0]        i_value,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [VALUE_BITS-1:0]        o_value,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [VALUE_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_next;
    logic                  push;
    logic                  pop;
    logic [LW-1:0]         level_next;
    logic [VALUE_BITS-1:0] head_next;

    // The head after this edge is either an older stored word or, when the buffer
    // drains to just the incoming word, i_value itself (not yet in mem).
    always_comb begin
        push        = i_valid && o_ready;
        pop         = o_valid && i_ready;
        level_next  = level + LW'(push) - LW'(pop);
        rd_ptr_next = rd_ptr + PW'(pop);
        head_next   = '0;
        if (level_next != '0) begin
            if (push && (wr_ptr == rd_ptr_next)) begin
                head_next = i_value;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= i_value;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
            o_value <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr  <= rd_ptr_next;
            level   <= level_next;
            o_ready <= (level_next != FULL_LEVEL);
            o_valid <= (level_next != '0);
            o_value <= head_next;
        end
    end

    a_level_bound : assert property (@(posedge clock) disable iff (!reset_n)
        level <= FULL_LEVEL);
    a_valid_level : assert property (@(posedge clock) disable iff (!reset_n)
        o_valid == (level != '0));

endmodule

// File: tb/tb_handshake_fifo.sv
// Randomized and directed bench for handshake_fifo, checked against a queue-based
// model of the buffer contents.
module tb_handshake_fifo;

    localparam int VALUE_BITS = 8;
    localparam int DEPTH      = 4;
    localparam int N_WORDS    = 1000;
    localparam int MAX_DELAY  = 10;

    logic                       clock;
    logic                       reset_n;
    logic [VALUE_BITS-1:0]      i_value;
    logic                       i_valid;
    logic                       o_ready;
    logic [VALUE_BITS-1:0]      o_value;
    logic                       o_valid;
    logic                       i_ready;
    logic [$clog2(DEPTH+1)-1:0] level;

    handshake_fifo #(.VALUE_BITS(VALUE_BITS), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .i_value (i_value),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_value (o_value),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .level   (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [VALUE_BITS-1:0] model_q[$];
    bit                    model_ready = 1'b0;
    bit                    model_pushed;
    bit                    model_popped;
    int                    dut_pops = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare outputs.
    task automatic applyStimulus(input bit rst_n, input bit valid, input logic [VALUE_BITS-1:0] value,
                                 input bit ready);
        reset_n = rst_n;
        i_valid = valid;
        i_value = value;
        i_ready = ready;
        if (o_valid === 1'b1 && ready) dut_pops++;
        @(posedge clock);
        model_pushed = 1'b0;
        model_popped = 1'b0;
        if (!rst_n) begin
            model_q.delete();
            model_ready = 1'b0;
        end else begin
            model_popped = (model_q.size() != 0) && ready;
            model_pushed = valid && model_ready;
            if (model_popped) void'(model_q.pop_front());
            if (model_pushed) model_q.push_back(value);
            model_ready = (model_q.size() < DEPTH);
        end
        #1;
        checkOutput("o_ready", 32'(o_ready), 32'(model_ready));
        checkOutput("o_valid", 32'(o_valid), 32'(model_q.size() != 0));
        checkOutput("o_value", 32'(o_value), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
        checkOutput("level", 32'(level), 32'(model_q.size()));
    endtask

    initial begin
        int guard;
        int sent;
        int recv;
        int cycles;
        int prod_wait;
        int cons_wait;
        logic [VALUE_BITS-1:0] cur_word;
        logic [VALUE_BITS-1:0] fill_words [4];

        reset_n = 1'b0;
        i_valid = 1'b0;
        i_value = '0;
        i_ready = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("reset_level", 32'(level), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("release_ready", 32'(o_ready), 32'd1);

        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1);
        checkOutput("single_value", 32'(o_value), 32'hA5);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("single_drained", 32'(o_valid), 32'd0);

        fill_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, fill_words[i], 1'b0);
        checkOutput("fill_level", 32'(level), 32'd4);
        checkOutput("fill_ready", 32'(o_ready), 32'd0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
        checkOutput("full_hold_value", 32'(o_value), 32'h11);
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b1);
        checkOutput("pop_at_full_level", 32'(level), 32'd3);
        guard = 0;
        while (!model_pushed && guard < 10) begin
            applyStimulus(1'b1, 1'b1, 8'h55, 1'b1);
            guard++;
        end
        checkOutput("fill_55_accepted", 32'(model_pushed), 32'd1);
        guard = 0;
        while (model_q.size() != 0 && guard < 10) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
            guard++;
        end
        checkOutput("fill_drained", 32'(level), 32'd0);

        applyStimulus(1'b1, 1'b1, 8'h61, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h62, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h63 + 8'(i), 1'b1);
            checkOutput("simul_level", 32'(level), 32'd2);
        end
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'h90 + 8'(i), 1'b0);
        checkOutput("pre_reset_level", 32'(level), 32'd3);
        applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
        checkOutput("midreset_level", 32'(level), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h7E, 1'b0);
        checkOutput("after_reset_head", 32'(o_value), 32'h7E);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

        // Random traffic: producer holds each word until taken, both sides idle 0..MAX_DELAY.
        dut_pops  = 0;
        sent      = 0;
        recv      = 0;
        cycles    = 0;
        prod_wait = $urandom_range(0, MAX_DELAY);
        cons_wait = $urandom_range(0, MAX_DELAY);
        cur_word  = 8'($urandom_range(0, 255));
        while (recv < N_WORDS && cycles < 40000) begin
            applyStimulus(1'b1, (sent < N_WORDS) && (prod_wait == 0), cur_word, cons_wait == 0);
            if (model_pushed) begin
                sent++;
                cur_word  = 8'($urandom_range(0, 255));
                prod_wait = $urandom_range(0, MAX_DELAY);
            end else if (prod_wait > 0) begin
                prod_wait--;
            end
            if (model_popped) begin
                recv++;
                cons_wait = $urandom_range(0, MAX_DELAY);
            end else if (cons_wait > 0) begin
                cons_wait--;
            end
            checkOutput("level_bound", 32'(level <= DEPTH), 32'd1);
            cycles++;
        end
        checkOutput("random_received", 32'(recv), 32'(N_WORDS));
        checkOutput("random_dut_pops", 32'(dut_pops), 32'(N_WORDS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
